spi_req_arbiter: RTL and testbench

- Shares one spi_master (7-bit Hamming(7,4) frames) among NUM_REQ requesters using round-robin arbitration.
- Hamming-encodes the winner's 4-bit nibble and launches one SPI transaction.
- Waits for the master's finish pulse, then Hamming-decodes the returned 7-bit frame with single-error correction.
- Returns the corrected nibble plus status to the winning requester; sits between client logic and spi_master.

---
 rtl/spi_pkg.sv | 42 ++++
 rtl/spi_req_arbiter_if.sv | 38 +++
 rtl/hamming_decoder.sv | 23 ++
 rtl/spi_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_spi_req_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, FSM states and Hamming(7,4) helpers for spi_req_arbiter
package spi_pkg;

    localparam int FRAME_W = 7;
    localparam int NIB_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Frame layout, bit 6 down to bit 0: {p0, p1, d3, p2, d2, d1, d0}
    function automatic logic [FRAME_W-1:0] hamming_encode(input logic [NIB_W-1:0] d);
        logic p0;
        logic p1;
        logic p2;
        p0 = d[0] ^ d[2] ^ d[3];
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[1] ^ d[2];
        return {p0, p1, d[3], p2, d[2], d[1], d[0]};
    endfunction

    // Syndrome {s2,s1,s0} names the single frame bit that must be flipped
    function automatic logic [FRAME_W-1:0] syndrome_flip_mask(input logic [2:0] syn);
        logic [FRAME_W-1:0] mask;
        case (syn)
            3'b001:  mask = 7'b100_0000;
            3'b010:  mask = 7'b010_0000;
            3'b100:  mask = 7'b000_1000;
            3'b011:  mask = 7'b001_0000;
            3'b101:  mask = 7'b000_0100;
            3'b110:  mask = 7'b000_0010;
            3'b111:  mask = 7'b000_0001;
            default: mask = 7'b000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// rtl/spi_req_arbiter_if.sv - requester and spi_master bus bundle for spi_req_arbiter
interface spi_req_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2,
    parameter int ERR_CNT_W = 8
);
    import spi_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NIB_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ack;
    logic [NIB_W-1:0]         resp_data;
    logic [IDX_W-1:0]         resp_idx;
    logic                     resp_valid;
    logic                     resp_corrected;
    logic                     resp_timeout;
    logic [ERR_CNT_W-1:0]     err_count;
    logic                     busy;
    logic                     spi_start;
    logic [FRAME_W-1:0]       spi_data_in;
    logic                     spi_finish;
    logic [FRAME_W-1:0]       spi_data_out;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, spi_finish, spi_data_out,
        output req_ack, resp_data, resp_idx, resp_valid, resp_corrected,
               resp_timeout, err_count, busy, spi_start, spi_data_in
    );

    // Environment side: requesters plus spi_master
    modport master (
        output req_valid, req_data, spi_finish, spi_data_out,
        input  req_ack, resp_data, resp_idx, resp_valid, resp_corrected,
               resp_timeout, err_count, busy, spi_start, spi_data_in
    );

endinterface

// File: rtl/hamming_decoder.sv
// rtl/hamming_decoder.sv - combinational Hamming(7,4) single-error-correcting decoder
module hamming_decoder
    import spi_pkg::*;
(
    input  logic [FRAME_W-1:0] frame_i,
    output logic [NIB_W-1:0]   data_o,
    output logic               corrected_o
);

    logic [2:0]         syn;
    logic [FRAME_W-1:0] fixed;

    // Compute syndrome, flip the named bit, extract data bits {r4,r2,r1,r0}
    always_comb begin
        syn = {frame_i[3] ^ frame_i[0] ^ frame_i[1] ^ frame_i[2],
               frame_i[5] ^ frame_i[0] ^ frame_i[1] ^ frame_i[4],
               frame_i[6] ^ frame_i[0] ^ frame_i[2] ^ frame_i[4]};
        fixed       = frame_i ^ syndrome_flip_mask(syn);
        data_o      = {fixed[4], fixed[2], fixed[1], fixed[0]};
        corrected_o = |syn;
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin sharing of one Hamming-coded spi_master among requesters
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_req_arbiter_if.slave  bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic                 timeout_q, timeout_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [NIB_W-1:0]     grant_nib;
    int                   cand;

    logic [NIB_W-1:0]     dec_data;
    logic                 dec_corr;
    logic                 resp_v;

    hamming_decoder u_dec (
        .frame_i     (rx_q),
        .data_o      (dec_data),
        .corrected_o (dec_corr)
    );

    // Round-robin search: first asserted requester at or above rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_nib   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant_nib   = bus.req_data[NIB_W*cand +: NIB_W];
            end
        end
    end

    // Next-state logic for the transaction FSM and its datapath registers
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        timeout_d = timeout_q;
        tmr_d     = tmr_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) state_d = ST_ARB;
            end
            ST_ARB: begin
                // Requests may have vanished since IDLE; fall back if so
                if (grant_found) begin
                    idx_d     = grant_idx;
                    tx_d      = hamming_encode(grant_nib);
                    rx_d      = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmr_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter is 0 in the first WAIT cycle, so abort when it would
                // reach TIMEOUT-1: resp_valid then lands TIMEOUT cycles after spi_start.
                // Finish has priority over a simultaneous timeout.
                if (bus.spi_finish) begin
                    rx_d    = bus.spi_data_out;
                    state_d = ST_RESP;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 2)) begin
                    timeout_d = 1'b1;
                    rx_d      = '0;
                    state_d   = ST_RESP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                if (dec_corr && !timeout_q && (err_q != '1)) err_d = err_q + 1'b1;
                tx_d    = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            timeout_q <= 1'b0;
            tmr_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            timeout_q <= timeout_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
        end
    end

    // Response fields are forced to zero outside the RESP strobe
    assign resp_v             = (state_q == ST_RESP);
    assign bus.resp_valid     = resp_v;
    assign bus.req_ack        = resp_v ? (NUM_REQ'(1) << idx_q) : '0;
    assign bus.resp_idx       = resp_v ? idx_q : '0;
    assign bus.resp_data      = (resp_v && !timeout_q) ? dec_data : '0;
    assign bus.resp_corrected = resp_v && !timeout_q && dec_corr;
    assign bus.resp_timeout   = resp_v && timeout_q;
    assign bus.err_count      = err_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.spi_start      = (state_q == ST_ISSUE);
    assign bus.spi_data_in    = tx_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - directed table-driven bench for spi_req_arbiter
module tb_spi_req_arbiter;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_req_arbiter_if #(.NUM_REQ(4), .IDX_W(2), .ERR_CNT_W(8)) bus0 ();
    spi_req_arbiter_if #(.NUM_REQ(4), .IDX_W(2), .ERR_CNT_W(2)) bus1 ();

    spi_req_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYCLES(1024), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    spi_req_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYCLES(1024), .ERR_CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    assign bus1.req_valid    = bus0.req_valid;
    assign bus1.req_data     = bus0.req_data;
    assign bus1.spi_finish   = bus0.spi_finish;
    assign bus1.spi_data_out = bus0.spi_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] rd;
        logic [6:0]  flip;
        int          delay;
        bit          drop;
        logic [6:0]  exp_frame;
        logic [1:0]  exp_idx;
        logic [3:0]  exp_data;
        logic        exp_corr;
        int          exp_err;
        int          exp_err2;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(input string name, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus0.spi_start) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        bit seen;
        bus0.req_valid = v.rv;
        bus0.req_data  = v.rd;
        wait_start($sformatf("v%0d_start", i), seen);
        if (!seen) return;
        check($sformatf("v%0d_frame", i), 32'(bus0.spi_data_in), 32'(v.exp_frame));
        if (v.drop) bus0.req_valid = '0;
        @(negedge clk);
        check($sformatf("v%0d_start_pulse", i), 32'(bus0.spi_start), 32'd0);
        repeat (v.delay - 1) @(negedge clk);
        check($sformatf("v%0d_frame_stable", i), 32'(bus0.spi_data_in), 32'(v.exp_frame));
        bus0.spi_finish   = 1'b1;
        bus0.spi_data_out = v.exp_frame ^ v.flip;
        @(negedge clk);
        bus0.spi_finish   = 1'b0;
        bus0.spi_data_out = '0;
        check($sformatf("v%0d_resp_valid", i), 32'(bus0.resp_valid), 32'd1);
        check($sformatf("v%0d_ack", i), 32'(bus0.req_ack), 32'(4'b0001 << v.exp_idx));
        check($sformatf("v%0d_idx", i), 32'(bus0.resp_idx), 32'(v.exp_idx));
        check($sformatf("v%0d_data", i), 32'(bus0.resp_data), 32'(v.exp_data));
        check($sformatf("v%0d_corr", i), 32'(bus0.resp_corrected), 32'(v.exp_corr));
        check($sformatf("v%0d_tout", i), 32'(bus0.resp_timeout), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_valid_off", i), 32'(bus0.resp_valid), 32'd0);
        check($sformatf("v%0d_data_off", i), 32'(bus0.resp_data), 32'd0);
        check($sformatf("v%0d_idle", i), 32'(bus0.busy), 32'd0);
        check($sformatf("v%0d_err", i), 32'(bus0.err_count), 32'(v.exp_err));
        check($sformatf("v%0d_err_sat", i), 32'(bus1.err_count), 32'(v.exp_err2));
    endtask

    task automatic reset_mid_wait();
        bit seen;
        bus0.req_valid = 4'b0001;
        bus0.req_data  = 16'h000B;
        wait_start("rst_start", seen);
        repeat (5) @(negedge clk);
        bus0.req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_spi_start", 32'(bus0.spi_start), 32'd0);
        check("rst_spi_data_in", 32'(bus0.spi_data_in), 32'd0);
        check("rst_ack", 32'(bus0.req_ack), 32'd0);
        check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
        check("rst_err", 32'(bus0.err_count), 32'd0);
        check("rst_err_sat", 32'(bus1.err_count), 32'd0);
        bus0.spi_finish   = 1'b1;
        bus0.spi_data_out = 7'h33;
        @(negedge clk);
        bus0.spi_finish   = 1'b0;
        bus0.spi_data_out = '0;
        check("late_finish_valid", 32'(bus0.resp_valid), 32'd0);
        check("late_finish_busy", 32'(bus0.busy), 32'd0);
        @(negedge clk);
        check("late_finish_valid2", 32'(bus0.resp_valid), 32'd0);
        check("late_finish_ack", 32'(bus0.req_ack), 32'd0);
    endtask

    task automatic timeout_seq();
        bit seen;
        int cycles;
        bus0.req_valid = 4'b0001;
        bus0.req_data  = 16'h0005;
        wait_start("to_start", seen);
        bus0.req_valid = '0;
        cycles = 0;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (bus0.resp_valid) begin
                cycles = c;
                break;
            end
        end
        check("to_latency", 32'(cycles), 32'd1024);
        check("to_flag", 32'(bus0.resp_timeout), 32'd1);
        check("to_data", 32'(bus0.resp_data), 32'd0);
        check("to_corr", 32'(bus0.resp_corrected), 32'd0);
        check("to_ack", 32'(bus0.req_ack), 32'd1);
        @(negedge clk);
        check("to_idle", 32'(bus0.busy), 32'd0);
        check("to_flag_off", 32'(bus0.resp_timeout), 32'd0);
        check("to_err", 32'(bus0.err_count), 32'd2);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 16'h000B, 7'h00, 20, 1'b0, 7'h33, 2'd0, 4'hB, 1'b0, 0, 0};
        for (int k = 1; k <= 7; k++)
            vecs[k] = '{4'b0001, 16'h000B, 7'(1 << (k - 1)), 3, 1'b0, 7'h33, 2'd0, 4'hB, 1'b1,
                        k, (k < 3) ? k : 3};
        vecs[8]  = '{4'b1111, 16'h4321, 7'h00, 2, 1'b0, 7'h69, 2'd0, 4'h1, 1'b0, 0, 0};
        vecs[9]  = '{4'b1111, 16'h4321, 7'h00, 2, 1'b0, 7'h2A, 2'd1, 4'h2, 1'b0, 0, 0};
        vecs[10] = '{4'b1111, 16'h4321, 7'h00, 2, 1'b0, 7'h43, 2'd2, 4'h3, 1'b0, 0, 0};
        vecs[11] = '{4'b1111, 16'h4321, 7'h00, 2, 1'b0, 7'h4C, 2'd3, 4'h4, 1'b0, 0, 0};
        vecs[12] = '{4'b1111, 16'h4321, 7'h00, 2, 1'b0, 7'h69, 2'd0, 4'h1, 1'b0, 0, 0};
        vecs[13] = '{4'b0100, 16'h0B00, 7'h00, 4, 1'b1, 7'h33, 2'd2, 4'hB, 1'b0, 0, 0};
        vecs[14] = '{4'b1010, 16'h4000, 7'h40, 2, 1'b0, 7'h4C, 2'd3, 4'h4, 1'b1, 1, 1};
        vecs[15] = '{4'b1010, 16'h0020, 7'h01, 2, 1'b0, 7'h2A, 2'd1, 4'h2, 1'b1, 2, 2};

        rst_n             = 1'b0;
        bus0.req_valid    = '0;
        bus0.req_data     = '0;
        bus0.spi_finish   = 1'b0;
        bus0.spi_data_out = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", 32'(bus0.busy), 32'd0);
        check("reset_spi_start", 32'(bus0.spi_start), 32'd0);
        check("reset_spi_data_in", 32'(bus0.spi_data_in), 32'd0);
        check("reset_ack", 32'(bus0.req_ack), 32'd0);
        check("reset_resp_valid", 32'(bus0.resp_valid), 32'd0);
        check("reset_err", 32'(bus0.err_count), 32'd0);

        for (int i = 0; i < 16; i++) begin
            if (i == 8) reset_mid_wait();
            run_vec(i, vecs[i]);
        end

        timeout_seq();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
